// File: rtl/dspi_pkg.sv
// Shared DSPI encodings: backward instruction commands, control opcodes,
// packet type bit positions and the out-of-range read fill pattern.
package dspi_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        REWIND  = 2'd2,
        RESET   = 2'd3
    } instr_cmd_e;

    localparam int TYPE_DATA_BIT = 0;
    localparam int TYPE_CTRL_BIT = 1;

    localparam logic [1:0] TYPE_BUBBLE = 2'b00;
    localparam logic [1:0] TYPE_DATA   = 2'b01;
    localparam logic [1:0] TYPE_CTRL   = 2'b10;

    // Relative opcodes live in ChunkID[MSB-1:0] when ChunkID[MSB] is set.
    localparam int CP_R_CTRL_READ_REQUEST_32b  = 0;
    localparam int CP_R_CTRL_WRITE_32b         = 1;
    localparam int CP_A_CTRL_READ_RESPONSE_32b = 1;

    localparam logic [31:0] CTRL_READ_FILL = 32'hBADA_DD00;

endpackage

// File: rtl/dspi_pipe_stage.sv
// One registered slot of the DSPI packet bundle; reset empties the slot.
module dspi_pipe_stage #(
    parameter int DATA_WIDTH  = 512,
    parameter int SID_W       = 4,
    parameter int CKID_W      = 5,
    parameter int CHID_W      = 10,
    parameter int STATE_WIDTH = 32
)(
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [DATA_WIDTH-1:0]  i_data,
    input  logic [1:0]             i_type,
    input  logic                   i_last,
    input  logic [SID_W-1:0]       i_streamId,
    input  logic [CKID_W-1:0]      i_chunkId,
    input  logic [CHID_W-1:0]      i_channelId,
    input  logic [STATE_WIDTH-1:0] i_state,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic [1:0]             o_type,
    output logic                   o_last,
    output logic [SID_W-1:0]       o_streamId,
    output logic [CKID_W-1:0]      o_chunkId,
    output logic [CHID_W-1:0]      o_channelId,
    output logic [STATE_WIDTH-1:0] o_state
);

    logic [DATA_WIDTH-1:0]  r_data;
    logic [1:0]             r_type;
    logic                   r_last;
    logic [SID_W-1:0]       r_streamId;
    logic [CKID_W-1:0]      r_chunkId;
    logic [CHID_W-1:0]      r_channelId;
    logic [STATE_WIDTH-1:0] r_state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_data      <= '0;
            r_type      <= '0;
            r_last      <= 1'b0;
            r_streamId  <= '0;
            r_chunkId   <= '0;
            r_channelId <= '0;
            r_state     <= '0;
        end else begin
            r_data      <= i_data;
            r_type      <= i_type;
            r_last      <= i_last;
            r_streamId  <= i_streamId;
            r_chunkId   <= i_chunkId;
            r_channelId <= i_channelId;
            r_state     <= i_state;
        end
    end

    assign o_data      = r_data;
    assign o_type      = r_type;
    assign o_last      = r_last;
    assign o_streamId  = r_streamId;
    assign o_chunkId   = r_chunkId;
    assign o_channelId = r_channelId;
    assign o_state     = r_state;

endmodule

// File: rtl/dspi_ctrl_reg_node.sv
// DSPI pipeline node with a local control register file: consumes relative-addressed
// control packets aimed at itself and forwards everything else with fixed latency.
module dspi_ctrl_reg_node
    import dspi_pkg::*;
#(
    parameter int DATA_WIDTH                  = 512,
    parameter int STREAM_ID_NUM               = 16,
    parameter int CHUNK_ID_NUM                = 32,
    parameter int CHANNEL_ID_NUM              = 1024,
    parameter int STATE_WIDTH                 = 32,
    parameter int NUM_REGS                    = 8,
    parameter int LATENCY                     = 1,
    parameter int INSTRUCTION_WIDTH           = 2,
    parameter int INSTRUCTION_PARAMETER_WIDTH = 16
)(
    input  logic                                    clk,
    input  logic                                    rstn,
    input  logic [DATA_WIDTH-1:0]                   Front_Data,
    input  logic [1:0]                              Front_Type,
    input  logic                                    Front_Last,
    input  logic [$clog2(STREAM_ID_NUM)-1:0]        Front_StreamID,
    input  logic [$clog2(CHUNK_ID_NUM)-1:0]         Front_ChunkID,
    input  logic [$clog2(CHANNEL_ID_NUM)-1:0]       Front_ChannelID,
    input  logic [STATE_WIDTH-1:0]                  Front_State,
    output logic [DATA_WIDTH-1:0]                   Back_Data,
    output logic [1:0]                              Back_Type,
    output logic                                    Back_Last,
    output logic [$clog2(STREAM_ID_NUM)-1:0]        Back_StreamID,
    output logic [$clog2(CHUNK_ID_NUM)-1:0]         Back_ChunkID,
    output logic [$clog2(CHANNEL_ID_NUM)-1:0]       Back_ChannelID,
    output logic [STATE_WIDTH-1:0]                  Back_State,
    input  logic [INSTRUCTION_WIDTH-1:0]            Back_InstructionType,
    input  logic [$clog2(STREAM_ID_NUM)-1:0]        Back_InstructionStreamID,
    input  logic [$clog2(CHANNEL_ID_NUM)-1:0]       Back_InstructionChannelID,
    input  logic [INSTRUCTION_PARAMETER_WIDTH-1:0]  Back_InstructionParameter,
    output logic [INSTRUCTION_WIDTH-1:0]            Front_InstructionType,
    output logic [$clog2(STREAM_ID_NUM)-1:0]        Front_InstructionStreamID,
    output logic [$clog2(CHANNEL_ID_NUM)-1:0]       Front_InstructionChannelID,
    output logic [INSTRUCTION_PARAMETER_WIDTH-1:0]  Front_InstructionParameter,
    output logic [32*NUM_REGS-1:0]                  Reg_Out,
    output logic [NUM_REGS-1:0]                     Reg_WrStrobe
);

    localparam int SID_W  = $clog2(STREAM_ID_NUM);
    localparam int CKID_W = $clog2(CHUNK_ID_NUM);
    localparam int CHID_W = $clog2(CHANNEL_ID_NUM);
    localparam int OPW    = CKID_W - 1;
    localparam int NWORDS = DATA_WIDTH / 32;

    logic [31:0]            r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]    r_wrStrobe;

    logic                   w_isRel;
    logic [OPW-1:0]         w_opcode;
    logic [7:0]             w_addr;
    logic [31:0]            w_readVal;
    logic [NUM_REGS-1:0]    w_wrEn;

    logic [DATA_WIDTH-1:0]  w_nxtData;
    logic [1:0]             w_nxtType;
    logic                   w_nxtLast;
    logic [SID_W-1:0]       w_nxtStreamId;
    logic [CKID_W-1:0]      w_nxtChunkId;
    logic [CHID_W-1:0]      w_nxtChannelId;
    logic [STATE_WIDTH-1:0] w_nxtState;

    logic [DATA_WIDTH-1:0]  r_s1Data;
    logic [1:0]             r_s1Type;
    logic                   r_s1Last;
    logic [SID_W-1:0]       r_s1StreamId;
    logic [CKID_W-1:0]      r_s1ChunkId;
    logic [CHID_W-1:0]      r_s1ChannelId;
    logic [STATE_WIDTH-1:0] r_s1State;

    logic [INSTRUCTION_WIDTH-1:0]           r_instrType;
    logic [SID_W-1:0]                       r_instrStreamId;
    logic [CHID_W-1:0]                      r_instrChannelId;
    logic [INSTRUCTION_PARAMETER_WIDTH-1:0] r_instrParameter;

    assign w_isRel  = Front_ChunkID[CKID_W-1];
    assign w_opcode = Front_ChunkID[OPW-1:0];
    assign w_addr   = Front_State[7:0];

    // Stage-1 decode: illegal type 2'b11 is folded into a plain control beat.
    always_comb begin
        w_nxtData      = Front_Data;
        w_nxtType      = Front_Type;
        w_nxtLast      = Front_Last;
        w_nxtStreamId  = Front_StreamID;
        w_nxtChunkId   = Front_ChunkID;
        w_nxtChannelId = Front_ChannelID;
        w_nxtState     = Front_State;
        w_wrEn         = '0;
        w_readVal      = CTRL_READ_FILL;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_addr == 8'(i)) begin
                w_readVal = r_regs[i];
            end
        end
        if (Front_Type[TYPE_CTRL_BIT]) begin
            w_nxtType = TYPE_CTRL;
            if (w_isRel) begin
                if (Front_ChannelID != '0) begin
                    w_nxtChannelId = Front_ChannelID - CHID_W'(1);
                end else if (w_opcode == OPW'(CP_R_CTRL_READ_REQUEST_32b)) begin
                    w_nxtData      = {NWORDS{w_readVal}};
                    w_nxtLast      = 1'b1;
                    w_nxtChunkId   = {1'b0, OPW'(CP_A_CTRL_READ_RESPONSE_32b)};
                    w_nxtChannelId = '0;
                end else begin
                    w_nxtType = TYPE_BUBBLE;
                    if (w_opcode == OPW'(CP_R_CTRL_WRITE_32b)) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            w_wrEn[i] = (w_addr == 8'(i));
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wrStrobe <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wrEn[i]) begin
                    r_regs[i] <= Front_Data[31:0];
                end
            end
            r_wrStrobe <= w_wrEn;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1Data      <= '0;
            r_s1Type      <= '0;
            r_s1Last      <= 1'b0;
            r_s1StreamId  <= '0;
            r_s1ChunkId   <= '0;
            r_s1ChannelId <= '0;
            r_s1State     <= '0;
        end else begin
            r_s1Data      <= w_nxtData;
            r_s1Type      <= w_nxtType;
            r_s1Last      <= w_nxtLast;
            r_s1StreamId  <= w_nxtStreamId;
            r_s1ChunkId   <= w_nxtChunkId;
            r_s1ChannelId <= w_nxtChannelId;
            r_s1State     <= w_nxtState;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_instrType      <= INSTRUCTION_WIDTH'(IDLE);
            r_instrStreamId  <= '0;
            r_instrChannelId <= '0;
            r_instrParameter <= '0;
        end else begin
            r_instrType      <= Back_InstructionType;
            r_instrStreamId  <= Back_InstructionStreamID;
            r_instrChannelId <= Back_InstructionChannelID;
            r_instrParameter <= Back_InstructionParameter;
        end
    end

    logic [DATA_WIDTH-1:0]  w_pData      [LATENCY];
    logic [1:0]             w_pType      [LATENCY];
    logic                   w_pLast      [LATENCY];
    logic [SID_W-1:0]       w_pStreamId  [LATENCY];
    logic [CKID_W-1:0]      w_pChunkId   [LATENCY];
    logic [CHID_W-1:0]      w_pChannelId [LATENCY];
    logic [STATE_WIDTH-1:0] w_pState     [LATENCY];

    assign w_pData[0]      = r_s1Data;
    assign w_pType[0]      = r_s1Type;
    assign w_pLast[0]      = r_s1Last;
    assign w_pStreamId[0]  = r_s1StreamId;
    assign w_pChunkId[0]   = r_s1ChunkId;
    assign w_pChannelId[0] = r_s1ChannelId;
    assign w_pState[0]     = r_s1State;

    // Stages after the first only add delay so every beat sees exactly LATENCY cycles.
    for (genvar g = 1; g < LATENCY; g++) begin : g_delay
        dspi_pipe_stage #(
            .DATA_WIDTH  (DATA_WIDTH),
            .SID_W       (SID_W),
            .CKID_W      (CKID_W),
            .CHID_W      (CHID_W),
            .STATE_WIDTH (STATE_WIDTH)
        ) u_stage (
            .clk         (clk),
            .rstn        (rstn),
            .i_data      (w_pData[g-1]),
            .i_type      (w_pType[g-1]),
            .i_last      (w_pLast[g-1]),
            .i_streamId  (w_pStreamId[g-1]),
            .i_chunkId   (w_pChunkId[g-1]),
            .i_channelId (w_pChannelId[g-1]),
            .i_state     (w_pState[g-1]),
            .o_data      (w_pData[g]),
            .o_type      (w_pType[g]),
            .o_last      (w_pLast[g]),
            .o_streamId  (w_pStreamId[g]),
            .o_chunkId   (w_pChunkId[g]),
            .o_channelId (w_pChannelId[g]),
            .o_state     (w_pState[g])
        );
    end

    assign Back_Data      = w_pData[LATENCY-1];
    assign Back_Type      = w_pType[LATENCY-1];
    assign Back_Last      = w_pLast[LATENCY-1];
    assign Back_StreamID  = w_pStreamId[LATENCY-1];
    assign Back_ChunkID   = w_pChunkId[LATENCY-1];
    assign Back_ChannelID = w_pChannelId[LATENCY-1];
    assign Back_State     = w_pState[LATENCY-1];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regOut
        assign Reg_Out[32*g +: 32] = r_regs[g];
    end

    assign Reg_WrStrobe               = r_wrStrobe;
    assign Front_InstructionType      = r_instrType;
    assign Front_InstructionStreamID  = r_instrStreamId;
    assign Front_InstructionChannelID = r_instrChannelId;
    assign Front_InstructionParameter = r_instrParameter;

endmodule

// File: tb/tb_dspi_ctrl_reg_node.sv
// Self-checking bench for dspi_ctrl_reg_node: directed scenarios with literal
// expectations plus randomized traffic against a behavioural packet model.
module tb_dspi_ctrl_reg_node;
    import dspi_pkg::*;

    localparam int LAT  = 2;
    localparam int DW   = 512;
    localparam int NREG = 8;

    typedef struct {
        logic [1:0]   typ;
        logic         last;
        logic [3:0]   sid;
        logic [4:0]   ckid;
        logic [9:0]   chid;
        logic [31:0]  state;
        logic [DW-1:0] data;
    } beat_t;

    logic clk  = 1'b0;
    logic rstn = 1'b1;

    logic [DW-1:0] frontData  = '0;
    logic [1:0]    frontType  = '0;
    logic          frontLast  = 1'b0;
    logic [3:0]    frontSid   = '0;
    logic [4:0]    frontCk    = '0;
    logic [9:0]    frontCh    = '0;
    logic [31:0]   frontState = '0;
    logic [1:0]    backInstrType  = '0;
    logic [3:0]    backInstrSid   = '0;
    logic [9:0]    backInstrCh    = '0;
    logic [15:0]   backInstrParam = '0;

    logic [DW-1:0]     Back_Data;
    logic [1:0]        Back_Type;
    logic              Back_Last;
    logic [3:0]        Back_StreamID;
    logic [4:0]        Back_ChunkID;
    logic [9:0]        Back_ChannelID;
    logic [31:0]       Back_State;
    logic [1:0]        Front_InstructionType;
    logic [3:0]        Front_InstructionStreamID;
    logic [9:0]        Front_InstructionChannelID;
    logic [15:0]       Front_InstructionParameter;
    logic [32*NREG-1:0] Reg_Out;
    logic [NREG-1:0]   Reg_WrStrobe;

    int checks   = 0;
    int failures = 0;

    beat_t       expQ[$];
    logic [31:0] modelRegs [NREG];
    logic [NREG-1:0] modelStrobe = '0;
    logic [1:0]  expInstrType  = '0;
    logic [3:0]  expInstrSid   = '0;
    logic [9:0]  expInstrCh    = '0;
    logic [15:0] expInstrParam = '0;
    logic [DW-1:0] dBeat;

    always #5 clk = ~clk;

    dspi_ctrl_reg_node #(
        .DATA_WIDTH                  (DW),
        .STREAM_ID_NUM               (16),
        .CHUNK_ID_NUM                (32),
        .CHANNEL_ID_NUM              (1024),
        .STATE_WIDTH                 (32),
        .NUM_REGS                    (NREG),
        .LATENCY                     (LAT),
        .INSTRUCTION_WIDTH           (2),
        .INSTRUCTION_PARAMETER_WIDTH (16)
    ) dut (
        .clk                        (clk),
        .rstn                       (rstn),
        .Front_Data                 (frontData),
        .Front_Type                 (frontType),
        .Front_Last                 (frontLast),
        .Front_StreamID             (frontSid),
        .Front_ChunkID              (frontCk),
        .Front_ChannelID            (frontCh),
        .Front_State                (frontState),
        .Back_Data                  (Back_Data),
        .Back_Type                  (Back_Type),
        .Back_Last                  (Back_Last),
        .Back_StreamID              (Back_StreamID),
        .Back_ChunkID               (Back_ChunkID),
        .Back_ChannelID             (Back_ChannelID),
        .Back_State                 (Back_State),
        .Back_InstructionType       (backInstrType),
        .Back_InstructionStreamID   (backInstrSid),
        .Back_InstructionChannelID  (backInstrCh),
        .Back_InstructionParameter  (backInstrParam),
        .Front_InstructionType      (Front_InstructionType),
        .Front_InstructionStreamID  (Front_InstructionStreamID),
        .Front_InstructionChannelID (Front_InstructionChannelID),
        .Front_InstructionParameter (Front_InstructionParameter),
        .Reg_Out                    (Reg_Out),
        .Reg_WrStrobe               (Reg_WrStrobe)
    );

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // What the node must emit for one accepted beat, given the register contents at that moment.
    function automatic beat_t predict(input beat_t b);
        beat_t r = b;
        int addr = int'(b.state[7:0]);
        logic [31:0] rv;
        if (b.typ[1]) begin
            r.typ = 2'b10;
            if (b.ckid[4]) begin
                if (b.chid != 10'd0) begin
                    r.chid = b.chid - 10'd1;
                end else if (b.ckid[3:0] == 4'd0) begin
                    rv     = (addr < NREG) ? modelRegs[addr] : 32'hBADA_DD00;
                    r.ckid = 5'b00001;
                    r.chid = 10'd0;
                    r.last = 1'b1;
                    r.data = {16{rv}};
                end else begin
                    r.typ = 2'b00;
                end
            end
        end
        return r;
    endfunction

    function automatic beat_t currentBeat();
        beat_t b;
        b.typ   = frontType;
        b.last  = frontLast;
        b.sid   = frontSid;
        b.ckid  = frontCk;
        b.chid  = frontCh;
        b.state = frontState;
        b.data  = frontData;
        return b;
    endfunction

    function automatic logic [32*NREG-1:0] flattenRegs();
        logic [32*NREG-1:0] f;
        for (int i = 0; i < NREG; i++) f[32*i +: 32] = modelRegs[i];
        return f;
    endfunction

    function automatic logic [DW-1:0] randData();
        logic [DW-1:0] d;
        for (int i = 0; i < DW/32; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    initial begin
        for (int i = 0; i < NREG; i++) modelRegs[i] = '0;
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            expQ.delete();
            for (int i = 0; i < NREG; i++) modelRegs[i] <= '0;
            modelStrobe   <= '0;
            expInstrType  <= '0;
            expInstrSid   <= '0;
            expInstrCh    <= '0;
            expInstrParam <= '0;
        end else begin
            expQ.push_back(predict(currentBeat()));
            modelStrobe <= '0;
            if (frontType[1] && frontCk[4] && frontCh == 10'd0 && frontCk[3:0] == 4'd1
                && frontState[7:0] < 8'(NREG)) begin
                modelRegs[frontState[2:0]] <= frontData[31:0];
                modelStrobe <= NREG'(1) << frontState[2:0];
            end
            expInstrType  <= backInstrType;
            expInstrSid   <= backInstrSid;
            expInstrCh    <= backInstrCh;
            expInstrParam <= backInstrParam;
        end
    end

    task automatic checkBeat(input beat_t e);
        checkOutput("backType", DW'(Back_Type), DW'(e.typ));
        if (e.typ != 2'b00) begin
            checkOutput("backData",  Back_Data, e.data);
            checkOutput("backLast",  DW'(Back_Last), DW'(e.last));
            checkOutput("backSid",   DW'(Back_StreamID), DW'(e.sid));
            checkOutput("backChunk", DW'(Back_ChunkID), DW'(e.ckid));
            checkOutput("backChan",  DW'(Back_ChannelID), DW'(e.chid));
            checkOutput("backState", DW'(Back_State), DW'(e.state));
        end
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            checkOutput("rstBackType",  DW'(Back_Type), DW'(0));
            checkOutput("rstInstrType", DW'(Front_InstructionType), DW'(0));
            checkOutput("rstRegOut",    DW'(Reg_Out), DW'(0));
            checkOutput("rstStrobe",    DW'(Reg_WrStrobe), DW'(0));
        end else begin
            if (expQ.size() == LAT) checkBeat(expQ.pop_front());
            else checkOutput("drainBackType", DW'(Back_Type), DW'(0));
            checkOutput("regOut",     DW'(Reg_Out), DW'(flattenRegs()));
            checkOutput("wrStrobe",   DW'(Reg_WrStrobe), DW'(modelStrobe));
            checkOutput("instrType",  DW'(Front_InstructionType), DW'(expInstrType));
            checkOutput("instrSid",   DW'(Front_InstructionStreamID), DW'(expInstrSid));
            checkOutput("instrChan",  DW'(Front_InstructionChannelID), DW'(expInstrCh));
            checkOutput("instrParam", DW'(Front_InstructionParameter), DW'(expInstrParam));
        end
    end

    task automatic applyStimulus(input logic [1:0] t, input logic l, input logic [3:0] s,
                                 input logic [4:0] ck, input logic [9:0] ch,
                                 input logic [31:0] st, input logic [DW-1:0] d);
        @(negedge clk);
        frontType  = t;
        frontLast  = l;
        frontSid   = s;
        frontCk    = ck;
        frontCh    = ch;
        frontState = st;
        frontData  = d;
    endtask

    task automatic applyBubble();
        applyStimulus(2'b00, 1'b0, 4'd0, 5'd0, 10'd0, 32'd0, '0);
    endtask

    task automatic randomBeat();
        logic [1:0]  t  = 2'($urandom_range(0, 3));
        logic [4:0]  ck = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 3))};
        logic [9:0]  ch = ($urandom_range(0, 2) == 0) ? 10'($urandom_range(0, 3)) : 10'd0;
        logic [7:0]  ad = ($urandom_range(0, 5) == 0) ? 8'd20 : 8'($urandom_range(0, 9));
        logic [31:0] st = {24'($urandom_range(0, 255)), ad};
        applyStimulus(t, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), ck, ch, st, randData());
        backInstrType  = 2'($urandom_range(0, 3));
        backInstrSid   = 4'($urandom_range(0, 15));
        backInstrCh    = 10'($urandom_range(0, 1023));
        backInstrParam = 16'($urandom_range(0, 65535));
    endtask

    initial begin
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        #2 rstn = 1'b1;

        // Relative write to register 3.
        applyStimulus(2'b10, 1'b0, 4'd1, 5'b10001, 10'd0, 32'd3, DW'(32'h1234_5678));
        applyBubble();
        checkOutput("litWrReg3", DW'(Reg_Out[127:96]), DW'(32'h1234_5678));
        checkOutput("litWrStrobe", DW'(Reg_WrStrobe), DW'(8'b0000_1000));
        applyBubble();
        checkOutput("litWrSlotType", DW'(Back_Type), DW'(2'b00));
        checkOutput("litStrobeOnce", DW'(Reg_WrStrobe), DW'(8'b0000_0000));

        // Write then immediately read back register 3.
        applyStimulus(2'b10, 1'b0, 4'd1, 5'b10001, 10'd0, 32'd3, DW'(32'hA5A5_A5A5));
        applyStimulus(2'b10, 1'b0, 4'd6, 5'b10000, 10'd0, 32'd3, '0);
        applyBubble();
        checkOutput("litRegA5", DW'(Reg_Out[127:96]), DW'(32'hA5A5_A5A5));
        applyBubble();
        checkOutput("litRespType",  DW'(Back_Type), DW'(2'b10));
        checkOutput("litRespChunk", DW'(Back_ChunkID), DW'(5'b00001));
        checkOutput("litRespLast",  DW'(Back_Last), DW'(1'b1));
        checkOutput("litRespData",  Back_Data, {16{32'hA5A5_A5A5}});
        checkOutput("litRespSid",   DW'(Back_StreamID), DW'(4'd6));

        // Relative read aimed five nodes downstream.
        applyStimulus(2'b10, 1'b0, 4'd2, 5'b10000, 10'd5, 32'd2, '0);
        applyBubble();
        checkOutput("litFwdNotYet", DW'(Back_Type), DW'(2'b00));
        applyBubble();
        checkOutput("litFwdType",  DW'(Back_Type), DW'(2'b10));
        checkOutput("litFwdChan",  DW'(Back_ChannelID), DW'(10'd4));
        checkOutput("litFwdChunk", DW'(Back_ChunkID), DW'(5'b10000));

        // Out-of-range read and write.
        applyStimulus(2'b10, 1'b0, 4'd3, 5'b10000, 10'd0, 32'd20, '0);
        applyBubble();
        applyBubble();
        checkOutput("litOorLow",  DW'(Back_Data[31:0]), DW'(32'hBADA_DD00));
        checkOutput("litOorHigh", DW'(Back_Data[511:480]), DW'(32'hBADA_DD00));
        applyStimulus(2'b10, 1'b0, 4'd3, 5'b10001, 10'd0, 32'd20, DW'(32'hDEAD_BEEF));
        applyBubble();
        checkOutput("litOorWrStrobe", DW'(Reg_WrStrobe), DW'(0));
        checkOutput("litOorWrRegs",   DW'(Reg_Out), DW'(256'(32'hA5A5_A5A5) << 96));
        applyBubble();

        // Data beat carrying a relative-looking ChunkID, then an absolute control beat.
        dBeat = randData();
        applyStimulus(2'b01, 1'b0, 4'd9, 5'b10000, 10'd0, 32'd3, dBeat);
        applyStimulus(2'b10, 1'b1, 4'd9, 5'b00011, 10'd7, 32'h55, '0);
        applyBubble();
        checkOutput("litDataType",  DW'(Back_Type), DW'(2'b01));
        checkOutput("litDataData",  Back_Data, dBeat);
        checkOutput("litDataRegs",  DW'(Reg_Out[127:96]), DW'(32'hA5A5_A5A5));
        applyBubble();
        checkOutput("litEosType",  DW'(Back_Type), DW'(2'b10));
        checkOutput("litEosChunk", DW'(Back_ChunkID), DW'(5'b00011));
        checkOutput("litEosChan",  DW'(Back_ChannelID), DW'(10'd7));
        checkOutput("litEosLast",  DW'(Back_Last), DW'(1'b1));

        // Backward instruction mirror.
        applyBubble();
        backInstrType  = 2'd2;
        backInstrSid   = 4'd7;
        backInstrCh    = 10'd9;
        backInstrParam = 16'h0042;
        applyBubble();
        checkOutput("litInstrType",  DW'(Front_InstructionType), DW'(2'd2));
        checkOutput("litInstrParam", DW'(Front_InstructionParameter), DW'(16'h0042));
        checkOutput("litInstrChan",  DW'(Front_InstructionChannelID), DW'(10'd9));

        repeat (500) randomBeat();

        // Asynchronous reset while beats and an instruction are in flight.
        applyStimulus(2'b01, 1'b0, 4'd1, 5'd0, 10'd0, 32'd0, randData());
        backInstrType = 2'd3;
        applyStimulus(2'b01, 1'b1, 4'd2, 5'd0, 10'd0, 32'd0, randData());
        applyStimulus(2'b01, 1'b0, 4'd3, 5'd0, 10'd0, 32'd0, randData());
        #2 rstn = 1'b0;
        #1;
        checkOutput("asyncRstBackType",  DW'(Back_Type), DW'(0));
        checkOutput("asyncRstInstrType", DW'(Front_InstructionType), DW'(0));
        checkOutput("asyncRstRegOut",    DW'(Reg_Out), DW'(0));
        @(negedge clk);
        @(negedge clk);
        #2 rstn = 1'b1;

        repeat (100) randomBeat();
        repeat (LAT + 2) applyBubble();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dspi_ctrl_reg_node.md
# dspi_ctrl_reg_node

Parametrised single-direction DSPI pipeline node with a built-in control register file. It sits in a module chain between an upstream (Front) and downstream (Back) neighbour. It services relative-addressed control read/write packets aimed at itself, generates absolute-addressed read responses, and forwards every other packet through a configurable-latency pipeline. Backward-path instructions pass upstream through a registered stage.

## Interface
- DATA_WIDTH, 512, data bus width; a multiple of 32.
- STREAM_ID_NUM, 16; CHUNK_ID_NUM, 32; CHANNEL_ID_NUM, 1024: ID ranges. Widths are $clog2 of each.
- STATE_WIDTH, 32, state/address field width.
- NUM_REGS, 8, number of 32-bit control registers; range 1..256.
- LATENCY, 1, forward pipeline depth in cycles; range 1..4.
- INSTRUCTION_WIDTH, 2; INSTRUCTION_PARAMETER_WIDTH, 16: backward instruction fields.
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- Front_Data/Type/Last/StreamID/ChunkID/ChannelID/State  in  DATA_WIDTH/2/1/SID/CKID/CHID/STATE_WIDTH  incoming packet beat.
- Back_Data/Type/Last/StreamID/ChunkID/ChannelID/State  out  same widths  outgoing packet beat.
- Back_InstructionType/StreamID/ChannelID/Parameter  in  backward instruction from downstream.
- Front_InstructionType/StreamID/ChannelID/Parameter  out  the same instruction, registered, sent upstream.
- Reg_Out  out  32*NUM_REGS  flat register contents; register i is at bits [32i+31:32i].
- Reg_WrStrobe  out  NUM_REGS  one-cycle pulse on the cycle register i updates.

## Operation
- Type encoding:
  - Type[1] marks a control beat; Type[0] marks a data beat.
  - 2'b00 is a bubble.
  - 2'b11 is illegal. It is treated as control, and Back_Type carries 2'b10.
- Addressing mode: ChunkID MSB = 1 means relative addressing; MSB = 0 means absolute. The opcode is ChunkID[CKID-2:0].
- Relative beat with ChannelID != 0: forwarded with ChannelID−1. All other fields are unchanged.
- Relative beat with ChannelID == 0: consumed by this node. The register address is State[7:0].
  - CTRL_WRITE_32b (opcode 1):
    - If address < NUM_REGS, register[address] ← Data[31:0] and Reg_WrStrobe[address] pulses.
    - If out of range, the write is ignored.
    - The slot is emitted as a bubble (Type 0).
  - CTRL_READ_REQUEST_32b (opcode 0): the slot is replaced by a response beat with these fields:
    - Type = 2'b10.
    - ChunkID = {1'b0, 1} (CP_A_CTRL_READ_RESPONSE_32b).
    - ChannelID = 0; StreamID and State unchanged; Last = 1.
    - Data = read value replicated in every 32-bit field.
    - Out-of-range reads return 32'hBADA_DD00.
  - Any other opcode: the slot becomes a bubble.
- Absolute control beats and data beats: forwarded intact.
- The register file is written at the end of the consume cycle. A read in the next beat returns the new value.
- Instruction path:
  - All four Back_Instruction* fields are registered into Front_Instruction* with one-cycle latency. There is no decoding.

## Timing
- Forward latency is exactly LATENCY cycles for every beat: forwarded, response or bubble. Throughput is one beat per cycle; there is no backpressure.
- Register read and write decode happen in pipeline stage 1. Stages 2..LATENCY are pure delay.
- Reset (rstn low, asynchronous) forces the following:
  - All Back_Type stages to 0.
  - Front_InstructionType to IDLE (2'd0).
  - All registers to 0 and Reg_WrStrobe to 0.
  - The other outputs to 0.
- Reset mid-pipeline discards every in-flight beat. The first valid output appears LATENCY cycles after the first beat accepted following rstn deassertion.
- Reg_Out is registered and reflects a write one cycle after the consume edge, coincident with Reg_WrStrobe.

## Structure
- Shared package dspi_pkg:
  - Instruction command encodings: IDLE=0, REQUEST=1, REWIND=2, RESET=3.
  - CP_A_* and CP_R_* opcode constants.
  - Type bit positions.
  - Response fill constant 32'hBADA_DD00.
- Sub-module dspi_pipe_stage: a registered stage for the full packet bundle with async reset clearing Type. It is instantiated LATENCY−1 times after stage 1.

## Test plan
- LATENCY=2: relative write, ChannelID=0, State=3, Data[31:0]=32'h1234_5678. Required: Reg_Out[127:96]=32'h1234_5678; Reg_WrStrobe=8'b0000_1000 for one cycle; Back_Type=0 two cycles later.
- Write reg 3 = 32'hA5A5_A5A5, then a read of reg 3 on the next cycle. Required: a response with Type=2'b10, ChunkID=5'b00001, all 16 fields = 32'hA5A5_A5A5, Last=1.
- Relative read with ChannelID=5. Required: forwarded with ChannelID=4, registers untouched, latency = LATENCY.
- Read with State=20 (NUM_REGS=8). Required: response data 32'hBADA_DD00. A write to State=20 changes no register and raises no strobe.
- Data beat followed by an absolute EOS beat, back-to-back. Required: both emerge unchanged and in order after LATENCY cycles.
- Back_InstructionType=REWIND, Parameter=16'h0042. Required: mirrored on Front_Instruction* one cycle later. Pulsing rstn mid-stream clears Back_Type and Front_InstructionType immediately, without waiting for a clock edge.
